// File: rtl/scan_decoder_if.sv
// -----------------------------------------------------------------------------
// scan_decoder_if
// Bundle of the control and output signals of scan_decoder.
//   master : drives en, mode, sel, div (and mask when built with
//            SCAN_DECODER_SKIP_MASK_EN); observes dec_out, idx, tick, wrap,
//            dbg_state.
//   slave  : the decoder side of the same signals.
// Handshake: there is no valid/ready pair. Every input is sampled on each
// rising clk edge, and every output is a register updated on that same edge.
// Optional macro: SCAN_DECODER_SKIP_MASK_EN adds the mask signal
// (OUT_W bits, 1 = skip that position while scanning).
// -----------------------------------------------------------------------------
interface scan_decoder_if #(
   parameter int SEL_W = 3,
   parameter int DIV_W = 16
);
   localparam int OUT_W = 2 ** SEL_W;

   logic             en;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [DIV_W-1:0] div;
`ifdef SCAN_DECODER_SKIP_MASK_EN
   logic [OUT_W-1:0] mask;
`endif
   logic [OUT_W-1:0] dec_out;
   logic [SEL_W-1:0] idx;
   logic             tick;
   logic             wrap;
   logic [1:0]       dbg_state;

`ifdef SCAN_DECODER_SKIP_MASK_EN
   modport master (output en, mode, sel, div, mask,
                   input  dec_out, idx, tick, wrap, dbg_state);
   modport slave  (input  en, mode, sel, div, mask,
                   output dec_out, idx, tick, wrap, dbg_state);
`else
   modport master (output en, mode, sel, div,
                   input  dec_out, idx, tick, wrap, dbg_state);
   modport slave  (input  en, mode, sel, div,
                   output dec_out, idx, tick, wrap, dbg_state);
`endif
endinterface

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
// Registered SEL_W-to-2^SEL_W one-hot decoder with a direct mode (decode an
// external select) and a scan mode (a prescaled counter steps the active
// output cyclically, for 7-segment digit and LED-bank multiplexing).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high, priority over all other inputs
//   bus  : scan_decoder_if.slave
//          en, mode, sel, div (+ mask) in; dec_out, idx, tick, wrap,
//          dbg_state (encoded FSM state: 0 IDLE, 1 DIRECT, 2 SCAN) out
// Parameters:
//   SEL_W   : select width, OUT_W = 2**SEL_W outputs
//   DIV_W   : width of the scan period input div
//   ACT_LOW : 1 = outputs active-low
// Optional macro: SCAN_DECODER_SKIP_MASK_EN enables the scan skip mask.
// Without it the decoder behaves as if mask were all zeros.
// -----------------------------------------------------------------------------
module scan_decoder #(
   parameter int SEL_W   = 3,
   parameter int DIV_W   = 16,
   parameter bit ACT_LOW = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   scan_decoder_if.slave bus
);
   localparam int OUT_W = 2 ** SEL_W;
   localparam logic [OUT_W-1:0] INACTIVE = ACT_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   state_e           state_q;
   logic [SEL_W-1:0] idx_q;
   logic [DIV_W-1:0] presc_q;
   logic [OUT_W-1:0] dec_q;
   logic             tick_q;
   logic             wrap_q;

   logic [OUT_W-1:0] mask_w;
   logic             all_masked;
   logic [SEL_W-1:0] step_idx_d;   // next unmasked position after idx_q
   logic [SEL_W-1:0] start_idx_d;  // first unmasked position at or after sel
   logic [SEL_W-1:0] cand_step;
   logic [SEL_W-1:0] cand_start;

`ifdef SCAN_DECODER_SKIP_MASK_EN
   assign mask_w = bus.mask;
`else
   assign mask_w = '0;
`endif

   // Output level for an active position; polarity applied before the register.
   function automatic logic [OUT_W-1:0] drive_level(input logic [SEL_W-1:0] i);
      logic [OUT_W-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return ACT_LOW ? ~oh : oh;
   endfunction

   // Searches run from the farthest candidate to the nearest, so the last
   // unmasked hit is the nearest one. For the step search, offset OUT_W
   // truncates to idx_q itself, which keeps a lone unmasked position selected.
   always_comb begin
      all_masked  = &mask_w;
      step_idx_d  = idx_q;
      start_idx_d = bus.sel;
      cand_step   = '0;
      cand_start  = '0;
      for (int k = OUT_W; k >= 1; k--) begin
         cand_step = idx_q + SEL_W'(k);
         if (!mask_w[cand_step]) step_idx_d = cand_step;
      end
      for (int k = OUT_W - 1; k >= 0; k--) begin
         cand_start = bus.sel + SEL_W'(k);
         if (!mask_w[cand_start]) start_idx_d = cand_start;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         presc_q <= '0;
         dec_q   <= INACTIVE;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (!bus.en) begin
         state_q <= IDLE;
         presc_q <= '0;
         dec_q   <= INACTIVE;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (!bus.mode) begin
         state_q <= DIRECT;
         idx_q   <= bus.sel;
         dec_q   <= drive_level(bus.sel);
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (state_q != SCAN) begin
         // Scan entry: load the start position; no tick for the load itself.
         state_q <= SCAN;
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         if (all_masked) begin
            dec_q <= INACTIVE;
         end else begin
            idx_q <= start_idx_d;
            dec_q <= drive_level(start_idx_d);
         end
      end else if (presc_q >= bus.div) begin
         // >= rather than == so a lowered div takes effect on the next cycle.
         presc_q <= '0;
         if (all_masked) begin
            dec_q  <= INACTIVE;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
         end else begin
            idx_q  <= step_idx_d;
            dec_q  <= drive_level(step_idx_d);
            tick_q <= 1'b1;
            wrap_q <= (step_idx_d <= idx_q);
         end
      end else begin
         presc_q <= presc_q + DIV_W'(1);
         dec_q   <= all_masked ? INACTIVE : drive_level(idx_q);
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end
   end

   assign bus.dec_out   = dec_q;
   assign bus.idx       = idx_q;
   assign bus.tick      = tick_q;
   assign bus.wrap      = wrap_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
// Drives scan_decoder (ACT_LOW=0) and a second copy (ACT_LOW=1) with the same
// stimulus. Each driven cycle pushes its expected {dec_out, idx, tick, wrap}
// onto exp_q; after the clock edge the entry is popped and compared against
// both copies (the active-low copy against the inverted dec_out).
// -----------------------------------------------------------------------------
module tb_scan_decoder;
   localparam int SEL_W = 3;
   localparam int DIV_W = 16;
   localparam int OUT_W = 8;
   localparam int W     = OUT_W + SEL_W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scan_decoder_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();
   scan_decoder_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus_n ();

   assign bus_n.en   = bus.en;
   assign bus_n.mode = bus.mode;
   assign bus_n.sel  = bus.sel;
   assign bus_n.div  = bus.div;
`ifdef SCAN_DECODER_SKIP_MASK_EN
   assign bus_n.mask = bus.mask;
`endif

   scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACT_LOW(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W), .ACT_LOW(1'b1)) dut_n (
      .clk (clk),
      .rst (rst),
      .bus (bus_n.slave)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   logic [SEL_W-1:0] m_idx;
   int               m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: inputs are already set; expectation is the state after the edge.
   task automatic step(input string tag, input logic [7:0] e_dec, input logic [2:0] e_idx,
                       input logic e_tick, input logic e_wrap);
      logic [W-1:0] e;
      logic [7:0]   inv;
      exp_q.push_back({e_dec, e_idx, e_tick, e_wrap});
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      inv = ~e[W-1 -: OUT_W];
      check({tag, "/dec"},    bus.dec_out,   e[W-1 -: OUT_W]);
      check({tag, "/dec_n"},  bus_n.dec_out, inv);
      check({tag, "/idx"},    bus.idx,       e[2 +: SEL_W]);
      check({tag, "/idx_n"},  bus_n.idx,     e[2 +: SEL_W]);
      check({tag, "/tick"},   bus.tick,      e[1]);
      check({tag, "/wrap"},   bus.wrap,      e[0]);
   endtask

   // Scan entry: sel captured, counter restarted, no tick.
   task automatic scan_enter(input string tag, input logic [2:0] s);
      bus.en   = 1'b1;
      bus.mode = 1'b1;
      bus.sel  = s;
      step(tag, 8'h01 << s, s, 1'b0, 1'b0);
      m_idx = s;
      m_cnt = 0;
   endtask

   // Steady scan; sel is randomised to show it is ignored after entry.
   task automatic scan_run(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         logic t;
         logic w;
         t = 1'b0;
         w = 1'b0;
         if (m_cnt >= int'(bus.div)) begin
            m_cnt = 0;
            w     = (m_idx == 3'd7);
            m_idx = m_idx + 3'd1;
            t     = 1'b1;
         end else begin
            m_cnt++;
         end
         bus.sel = 3'($urandom_range(0, 7));
         step(tag, 8'h01 << m_idx, m_idx, t, w);
      end
   endtask

   initial begin
      logic [2:0] s;
      rst      = 1'b1;
      bus.en   = 1'b1;
      bus.mode = 1'b0;
      bus.sel  = 3'd5;
      bus.div  = 16'd2;
`ifdef SCAN_DECODER_SKIP_MASK_EN
      bus.mask = 8'h00;
`endif
      // Reset with en=1: outputs inactive.
      step("reset0", 8'h00, 3'd0, 1'b0, 1'b0);
      step("reset1", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Direct: walk 0..7, then random selects.
      for (int i = 0; i < 8; i++) begin
         bus.sel = 3'(i);
         step("direct_walk", 8'h01 << i, 3'(i), 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         s       = 3'($urandom_range(0, 7));
         bus.sel = s;
         step("direct_rand", 8'h01 << s, s, 1'b0, 1'b0);
      end

      // Scan div=2 from 6: 6,6,6,7,7,7,0 (wrap),...
      bus.div = 16'd2;
      scan_enter("scan_div2_enter", 3'd6);
      scan_run("scan_div2", 12);

      // div=0: advance every cycle, tick held high, wrap once per 8.
      bus.div = 16'd0;
      scan_run("scan_div0", 16);

      // Random periods.
      bus.div = 16'($urandom_range(1, 4));
      scan_run("scan_rand_div", 15);

      // en drop for one cycle: inactive, idx held; restart from sel.
      bus.en = 1'b0;
      step("en_drop", 8'h00, m_idx, 1'b0, 1'b0);
      bus.div = 16'd0;
      scan_enter("reenable", 3'd3);
      scan_run("reenable_run", 5);

      // Reset mid-scan.
      rst = 1'b1;
      step("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst     = 1'b0;
      bus.div = 16'd1;
      scan_enter("post_reset_enter", 3'd5);
      scan_run("post_reset_run", 6);

      // Switch to direct mid-count.
      bus.mode = 1'b0;
      bus.sel  = 3'd3;
      step("to_direct", 8'h08, 3'd3, 1'b0, 1'b0);

`ifdef SCAN_DECODER_SKIP_MASK_EN
      // Direct ignores mask.
      bus.mask = 8'b1010_1010;
      bus.sel  = 3'd1;
      step("mask_direct", 8'h02, 3'd1, 1'b0, 1'b0);
      // Scan entry on masked sel=1 starts at 2; then 4,6,0(wrap),2,4.
      bus.mode = 1'b1;
      bus.div  = 16'd0;
      step("mask_enter", 8'h04, 3'd2, 1'b0, 1'b0);
      step("mask_s4",    8'h10, 3'd4, 1'b1, 1'b0);
      step("mask_s6",    8'h40, 3'd6, 1'b1, 1'b0);
      step("mask_s0",    8'h01, 3'd0, 1'b1, 1'b1);
      step("mask_s2",    8'h04, 3'd2, 1'b1, 1'b0);
      step("mask_s4b",   8'h10, 3'd4, 1'b1, 1'b0);
      // All masked: inactive, idx held, no tick.
      bus.mask = 8'hFF;
      step("mask_all0",  8'h00, 3'd4, 1'b0, 1'b0);
      step("mask_all1",  8'h00, 3'd4, 1'b0, 1'b0);
      // Unmask: plain step from 4 to 5.
      bus.mask = 8'h00;
      step("mask_clear", 8'h20, 3'd5, 1'b1, 1'b0);
`endif

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
